// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state type and address-field helpers for the data cache
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W = 5;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
  localparam int LINE_W = 8 * 32;
  localparam int WSEL_W = OFFSET_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] a);
    return a[2 +: WSEL_W];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage with combinational read, word-write and line-write ports
module dcache_array import dcache_pkg::*; #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BYTES = 32,
  localparam int IW = $clog2(NUM_LINES),
  localparam int OW = $clog2(LINE_BYTES),
  localparam int TW = 32 - IW - OW,
  localparam int LW = 8 * LINE_BYTES,
  localparam int SW = OW - 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic          rd_dirty,
  output logic [TW-1:0] rd_tag,
  output logic [LW-1:0] rd_line,
  input  logic          word_we,
  input  logic [IW-1:0] word_idx,
  input  logic [SW-1:0] word_sel,
  input  logic [31:0]   word_data,
  input  logic          line_we,
  input  logic [IW-1:0] line_idx,
  input  logic [TW-1:0] line_tag,
  input  logic [LW-1:0] line_data
);
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TW-1:0] tags [NUM_LINES];
  logic [LW-1:0] data [NUM_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_line = data[rd_idx];

  // status bits: cleared by reset, a refill makes the line valid and clean, a store dirties it
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[line_idx] <= 1'b1;
      dirty[line_idx] <= 1'b0;
    end else if (word_we) dirty[word_idx] <= 1'b1;

  // tag and data storage are never reset; valid guards their contents
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tags[line_idx] <= line_tag;
      data[line_idx] <= line_data;
    end
    if (word_we) data[word_idx][{word_sel, 5'b0} +: 32] <= word_data;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with stall and line handshake
module dcache_ctrl import dcache_pkg::*; #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BYTES = 32,
  localparam int IW = $clog2(NUM_LINES),
  localparam int OW = $clog2(LINE_BYTES),
  localparam int TW = 32 - IW - OW,
  localparam int LW = 8 * LINE_BYTES,
  localparam int SW = OW - 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_data_i,
  output logic [31:0]   cpu_data_o,
  output logic          cpu_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [LW-1:0] mem_data_o,
  input  logic [LW-1:0] mem_data_i,
  input  logic          mem_ack_i
);
  state_t state, state_nxt;
  logic [IW-1:0] idx, miss_idx;
  logic [TW-1:0] tag, miss_tag, rd_tag;
  logic [SW-1:0] sel;
  logic rd_valid, rd_dirty, hit, miss, victim_dirty, line_we;
  logic [LW-1:0] rd_line;
  logic unused_byte_bits;

  assign idx = cpu_addr_i[OW +: IW];
  assign tag = cpu_addr_i[31 -: TW];
  assign sel = cpu_addr_i[2 +: SW];
  assign unused_byte_bits = &{1'b0, cpu_addr_i[1:0]};
  assign hit = cpu_req_i && rd_valid && rd_tag == tag;
  assign miss = state == IDLE && cpu_req_i && !hit;
  assign victim_dirty = rd_valid && rd_dirty;
  assign line_we = state == REFILL && mem_ack_i;
  assign cpu_stall_o = cpu_req_i && !(state == IDLE && hit);
  assign cpu_data_o = rd_line[{sel, 5'b0} +: 32];

  dcache_array #(.NUM_LINES(NUM_LINES), .LINE_BYTES(LINE_BYTES)) u_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rd_idx(idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag(rd_tag),
    .rd_line(rd_line),
    .word_we(state == IDLE && hit && cpu_we_i),
    .word_idx(idx),
    .word_sel(sel),
    .word_data(cpu_data_i),
    .line_we(line_we),
    .line_idx(miss_idx),
    .line_tag(miss_tag),
    .line_data(mem_data_i)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;

  // next state: a miss evicts a dirty victim first, each ack advances one step
  always_comb begin
    state_nxt = state;
    if (miss) state_nxt = victim_dirty ? WRITEBACK : REFILL;
    else if (state == WRITEBACK && mem_ack_i) state_nxt = REFILL;
    else if (line_we) state_nxt = IDLE;
  end

  // registered memory request, held steady from assertion through its ack
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else if (miss) begin
      miss_idx <= idx;
      miss_tag <= tag;
      mem_req_o <= 1'b1;
      mem_we_o <= victim_dirty;
      mem_addr_o <= {victim_dirty ? rd_tag : tag, idx, {OW{1'b0}}};
      mem_data_o <= rd_line;
    end else if (state == WRITEBACK && mem_ack_i) begin
      mem_we_o <= 1'b0;
      mem_addr_o <= {miss_tag, miss_idx, {OW{1'b0}}};
    end else if (line_we) begin
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a req/ack memory model and decoupled CPU/memory monitors
module tb_dcache_ctrl;
  logic clk_i = 0, rst_i = 0, cpu_req_i = 0, cpu_we_i = 0;
  logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o, mem_addr_o;
  logic cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic model_ack = 0, spur_ack = 0;
  logic [255:0] mem_data_o, mem_data_i = '0;
  int tests = 0, fails = 0, ack_delay = 3;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int stall;} cpu_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic chk; logic [31:0] w1;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [255:0] mem_store [logic [31:0]];

  assign mem_ack_i = model_ack | spur_ack;
  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  function automatic logic [31:0] init_word(input logic [31:0] la, input int w);
    return 32'hA000_0000 | (la + 32'(w * 4));
  endfunction

  function automatic logic [255:0] read_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la, w);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic chk, input logic [31:0] w1);
    mem_q.push_back('{we: we, addr: addr, chk: chk, w1: w1});
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_data, input int exp_stall);
    int n;
    cpu_q.push_back('{we: we, addr: addr, data: exp_data, stall: exp_stall});
    cpu_req_i = 1;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_data_i = data;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
    end
    if (n == 200) begin
      tests++;
      fails++;
      $display("FAIL access_timeout: addr %h still stalled after 200 cycles", addr);
    end
    @(posedge clk_i);
    #1 cpu_req_i = 0;
  endtask

  // memory model: acks after ack_delay request cycles, checks each completed request
  initial begin
    int cnt = 0;
    mem_exp_t e;
    forever begin
      @(negedge clk_i);
      model_ack = 0;
      if (!mem_req_o) cnt = 0;
      else if (++cnt >= ack_delay) begin
        cnt = 0;
        model_ack = 1;
        if (mem_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: we %0b addr %h, no request expected", mem_we_o, mem_addr_o);
        end else begin
          e = mem_q.pop_front();
          check("mem_we", {31'b0, mem_we_o}, {31'b0, e.we});
          check("mem_addr", mem_addr_o, e.addr);
          if (e.chk) check("wb_word1", mem_data_o[63:32], e.w1);
        end
        if (mem_we_o) mem_store[mem_addr_o] = mem_data_o;
        else mem_data_i = read_line(mem_addr_o);
      end
    end
  end

  // CPU monitor: counts stall cycles and checks each completed access against the scoreboard
  initial begin
    int sc = 0;
    cpu_exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) sc = 0;
      else if (cpu_req_i) begin
        if (cpu_stall_o) sc++;
        else if (cpu_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cpu_unexpected: access %h completed with nothing expected", cpu_addr_i);
        end else begin
          e = cpu_q.pop_front();
          check("stall_cycles", sc, e.stall);
          if (!e.we) check("load_data", cpu_data_o, e.data);
          sc = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] la;
    cpu_req_i = 1;
    cpu_addr_i = 32'h400;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", {31'b0, cpu_stall_o}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    cpu_req_i = 0;
    @(posedge clk_i);
    #1 rst_i = 1;
    @(negedge clk_i);
    check("idle_stall", {31'b0, cpu_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    exp_mem(0, 32'h400, 0, 0);
    access(0, 32'h400, 0, 32'hA000_0400, 4);
    access(1, 32'h404, 32'hDEAD_BEEF, 0, 0);
    access(0, 32'h404, 0, 32'hDEAD_BEEF, 0);
    exp_mem(1, 32'h400, 1, 32'hDEAD_BEEF);
    exp_mem(0, 32'h800, 0, 0);
    access(0, 32'h800, 0, 32'hA000_0800, 7);
    exp_mem(0, 32'hC00, 0, 0);
    access(0, 32'hC00, 0, 32'hA000_0C00, 4);
    exp_mem(0, 32'h400, 0, 0);
    access(0, 32'h404, 0, 32'hDEAD_BEEF, 4);
    ack_delay = 10;
    cpu_req_i = 1;
    cpu_we_i = 0;
    cpu_addr_i = 32'h1000;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("refill_pending", {31'b0, mem_req_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 0;
    #1;
    check("abort_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("abort_stall", {31'b0, cpu_stall_o}, 32'd1);
    ack_delay = 3;
    @(posedge clk_i);
    #1 rst_i = 1;
    exp_mem(0, 32'h1000, 0, 0);
    access(0, 32'h1000, 0, 32'hA000_1000, 4);
    spur_ack = 1;
    @(negedge clk_i);
    check("spur_idle_req", {31'b0, mem_req_o}, 32'd0);
    access(0, 32'h1008, 0, 32'hA000_1008, 0);
    spur_ack = 0;
    @(negedge clk_i);
    check("spur_hit_req", {31'b0, mem_req_o}, 32'd0);
    @(posedge clk_i);
    #1 ack_delay = 1;
    for (int i = 0; i < 32; i++) begin
      la = 32'h2000 + 32'(i * 32);
      exp_mem(0, la, 0, 0);
      access(0, la + 32'((i % 8) * 4), 0, init_word(la, i % 8), 2);
    end
    for (int i = 0; i < 32; i++) begin
      la = 32'h2000 + 32'(i * 32);
      access(1, la + 32'(((i + 3) % 8) * 4), 32'h5000_0000 + 32'(i), 0, 0);
      access(0, la + 32'(((i + 3) % 8) * 4), 0, 32'h5000_0000 + 32'(i), 0);
      access(0, la + 32'((i % 8) * 4), 0, init_word(la, i % 8), 0);
    end
    repeat (5) @(posedge clk_i);
    check("cpu_queue_left", cpu_q.size(), 32'd0);
    check("mem_queue_left", mem_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
